// File: rtl/pipe_if_stage.sv
// pipe_if_stage -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the PC register, a word-addressed instruction RAM with a write/load
// port, next-PC selection (pc+4, register jump, branch, J-type jump) and the
// IF/ID pipeline register with stall, flush and valid tracking.
//
// Optional feature macro: PIPE_IF_MISALIGN_TRAP_EN
//   defined   : a misaligned next PC redirects to TRAP_PC, pulses
//               misalign_trap for one cycle and bubbles IF/ID.
//   undefined : next-PC bits [1:0] are forced to 00, misalign_trap is 0.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   stall                hold PC and IF/ID (a redirect still updates PC)
//   flush                load a bubble into IF/ID (wins over stall)
//   pcsource[1:0]        00 pc+4, 01 pc_jr, 10 pc_br, 11 jump
//   pc_jr, pc_br, jidx   redirect targets / J-type index
//   ram_wena/waddr/wdata instruction RAM write port
//   pc                   current PC
//   if_id_instr/pc4      latched instruction and its pc+4
//   if_id_valid          IF/ID holds a real instruction
//   misalign_trap        one-cycle pulse while pc = TRAP_PC after a trap
module pipe_if_stage #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       pc_jr,
  input  logic [31:0]       pc_br,
  input  logic [25:0]       jidx,
  input  logic              ram_wena,
  input  logic [ADDR_W-1:0] ram_waddr,
  input  logic [31:0]       ram_wdata,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc4,
  output logic              if_id_valid,
  output logic              misalign_trap
);

  logic [31:0] pc_p0;
  logic [31:0] pc4_p0;
  logic [31:0] redirect_pc_p0;
  logic [31:0] sel_pc_p0;
  logic [31:0] next_pc_p0;
  logic        misalign_p0;
  logic        bubble_p0;
  logic [31:0] fetch_word_p0;

  logic [31:0] instr_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;

  logic [31:0] mem [0:(2**ADDR_W)-1];

  // ---- stage p0: PC, next-PC selection, instruction RAM ----
  assign pc4_p0        = pc_p0 + 32'd4;
  assign fetch_word_p0 = mem[pc_p0[ADDR_W+1:2]];

  always_comb begin
    redirect_pc_p0 = pc4_p0;
    case (pcsource)
      2'b01:   redirect_pc_p0 = pc_jr;
      2'b10:   redirect_pc_p0 = pc_br;
      2'b11:   redirect_pc_p0 = {pc4_p0[31:28], jidx, 2'b00};
      default: redirect_pc_p0 = pc4_p0;
    endcase
  end

  // A redirect is applied even under stall so it is never dropped.
  always_comb begin
    sel_pc_p0 = pc4_p0;
    if (pcsource != 2'b00) sel_pc_p0 = redirect_pc_p0;
    else if (stall)        sel_pc_p0 = pc_p0;
  end

`ifdef PIPE_IF_MISALIGN_TRAP_EN
  assign misalign_p0 = (sel_pc_p0[1:0] != 2'b00);
  assign next_pc_p0  = misalign_p0 ? TRAP_PC : sel_pc_p0;
`else
  assign misalign_p0 = 1'b0;
  assign next_pc_p0  = sel_pc_p0 & ~32'h0000_0003;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_p0 <= RESET_PC;
    else        pc_p0 <= next_pc_p0;
  end

  // Nonblocking write: a same-cycle fetch of this word still sees old data.
  always_ff @(posedge clk) begin
    if (ram_wena) mem[ram_waddr] <= ram_wdata;
  end

  // ---- stage p1: IF/ID pipeline register ----
  assign bubble_p0 = flush | misalign_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1 <= NOP_WORD;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
    end else if (bubble_p0) begin
      instr_p1 <= NOP_WORD;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
    end else if (!stall) begin
      instr_p1 <= fetch_word_p0;
      pc4_p1   <= pc4_p0;
      vld_p1   <= 1'b1;
    end
  end

`ifdef PIPE_IF_MISALIGN_TRAP_EN
  logic trap_p1;

  // High exactly for the cycle in which pc holds TRAP_PC after a trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_p1 <= 1'b0;
    else        trap_p1 <= misalign_p0;
  end

  assign misalign_trap = trap_p1;
`else
  assign misalign_trap = 1'b0;
`endif

  assign pc          = pc_p0;
  assign if_id_instr = instr_p1;
  assign if_id_pc4   = pc4_p1;
  assign if_id_valid = vld_p1;

endmodule

// File: tb/tb_pipe_if_stage.sv
module tb_pipe_if_stage;

  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              flush;
  logic [1:0]        pcsource;
  logic [31:0]       pc_jr;
  logic [31:0]       pc_br;
  logic [25:0]       jidx;
  logic              ram_wena;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;
  logic [31:0]       pc;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_pc4;
  logic              if_id_valid;
  logic              misalign_trap;

  pipe_if_stage #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .TRAP_PC  (32'h0000_0080),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .pcsource      (pcsource),
    .pc_jr         (pc_jr),
    .pc_br         (pc_br),
    .jidx          (jidx),
    .ram_wena      (ram_wena),
    .ram_waddr     (ram_waddr),
    .ram_wdata     (ram_wdata),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .misalign_trap (misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        trap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".pc"},    pc,                   e.pc);
    chk({tag, ".instr"}, if_id_instr,          e.instr);
    chk({tag, ".pc4"},   if_id_pc4,            e.pc4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
    chk({tag, ".trap"},  {31'd0, misalign_trap}, {31'd0, e.trap});
  endtask

  // Push the expectation for the edge about to happen, then pop and compare.
  task automatic tick(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_valid, input logic e_trap);
    exp_t e;
    e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_valid; e.trap = e_trap;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; pcsource = 2'b00;
    pc_jr = 32'd0; pc_br = 32'd0; jidx = 26'd0;
    ram_wena = 1'b0; ram_waddr = '0; ram_wdata = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t rst_e;
    rst_e.pc = 32'd0; rst_e.instr = 32'd0; rst_e.pc4 = 32'd0; rst_e.valid = 1'b0; rst_e.trap = 1'b0;

    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Load RAM while in reset: words 0..7 = 11,22,..,88 and word 31 = FF.
    for (int i = 0; i < 9; i++) begin
      ram_wena  = 1'b1;
      ram_waddr = (i == 8) ? 5'd31 : 5'(i);
      ram_wdata = (i == 8) ? 32'hFF : 32'(8'h11 * (i + 1));
      @(posedge clk);
      #1;
    end
    ram_wena = 1'b0;
    check_outputs("reset", rst_e);
    rst_n = 1'b1;

    // Sequential fetch
    tick("seq0", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0);
    tick("seq1", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0);

    // Stall for 3 edges at pc = 8
    stall = 1'b1;
    tick("stall0", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0);
    tick("stall1", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0);
    tick("stall2", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0);
    stall = 1'b0;
    tick("resume0", 32'hC,  32'h33, 32'hC,  1'b1, 1'b0);
    tick("resume1", 32'h10, 32'h44, 32'h10, 1'b1, 1'b0);

    // Back to pc = 4, then jr to 0x10 with flush
    pcsource = 2'b01; pc_jr = 32'h4;
    tick("jr_to4", 32'h4, 32'h55, 32'h14, 1'b1, 1'b0);
    pc_jr = 32'h10; flush = 1'b1;
    tick("jr_flush", 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
    pcsource = 2'b00; flush = 1'b0;
    tick("after_flush", 32'h14, 32'h55, 32'h14, 1'b1, 1'b0);
    tick("seq_18", 32'h18, 32'h66, 32'h18, 1'b1, 1'b0);

    // Jump under stall: PC still redirects, IF/ID holds
    pcsource = 2'b11; jidx = 26'h000_0005; stall = 1'b1;
    tick("jump_stall", 32'h14, 32'h66, 32'h18, 1'b1, 1'b0);
    pcsource = 2'b00; stall = 1'b0;
    tick("after_jump", 32'h18, 32'h66, 32'h18, 1'b1, 1'b0);

    // PC wrap
    pcsource = 2'b01; pc_jr = 32'hFFFF_FFFC;
    tick("to_top", 32'hFFFF_FFFC, 32'h77, 32'h1C, 1'b1, 1'b0);
    pcsource = 2'b00;
    tick("wrap", 32'h0, 32'hFF, 32'h0, 1'b1, 1'b0);
    tick("wseq0", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0);
    tick("wseq1", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0);

    // Write word 2 while it is being fetched: old value captured
    ram_wena = 1'b1; ram_waddr = 5'd2; ram_wdata = 32'hAA;
    tick("wr_same", 32'hC, 32'h33, 32'hC, 1'b1, 1'b0);
    ram_wena = 1'b0;
    pcsource = 2'b01; pc_jr = 32'h8;
    tick("back_to8", 32'h8, 32'h44, 32'h10, 1'b1, 1'b0);
    pcsource = 2'b00;
    tick("refetch2", 32'hC, 32'hAA, 32'hC, 1'b1, 1'b0);

    // Misaligned branch target
    pcsource = 2'b10; pc_br = 32'h0000_0006;
`ifdef PIPE_IF_MISALIGN_TRAP_EN
    tick("mis_br", 32'h80, 32'h0, 32'h0, 1'b0, 1'b1);
    pcsource = 2'b00;
    tick("mis_after", 32'h84, 32'h11, 32'h84, 1'b1, 1'b0);
`else
    tick("mis_br", 32'h4, 32'h44, 32'h10, 1'b1, 1'b0);
    pcsource = 2'b00;
    tick("mis_after", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1 check_outputs("async_rst", rst_e);
    @(posedge clk);
    #1 check_outputs("rst_hold", rst_e);
    rst_n = 1'b1;
    tick("post_rst", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0);

    // Flush and stall together: PC holds, IF/ID bubbles
    stall = 1'b1; flush = 1'b1;
    tick("flush_stall", 32'h4, 32'h0, 32'h0, 1'b0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    tick("fs_after", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
